muldiv_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers. It sits directly downstream of the register file and consumes the `rs`/`rt` read-port values for MULT/MULTU/DIV/DIVU/MTHI/MTLO. Its `hi`/`lo` outputs feed back into the `rdd` write-back mux for MFHI/MFLO. Every multiply or divide takes a fixed 33 cycles, and the core stalls on `busy`.

---
 rtl/muldiv_unit.sv | 132 +++++++++++++
 tb/tb_muldiv_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: 33-cycle iterative multiply/divide with HI/LO registers.
// Shift-add multiply (LSB first) and restoring divide (MSB first) on magnitudes; signs fixed in FIN.
module muldiv_unit (
    input  logic        RF_CLK,
    input  logic        RF_RST,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        mthi,
    input  logic        mtlo,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_zero
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t      state_q, state_d;
    logic [5:0]  count_q, count_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [63:0] acc_q, acc_d;
    logic [32:0] rem_q, rem_d;
    logic        neg_q, neg_d, rneg_q, rneg_d, done_q, done_d, dz_q, dz_d;
    logic        rs_neg, rt_neg;
    logic [31:0] rs_mag, rt_mag, quo, rmd, dividend;
    logic [32:0] sum, shl, diff;
    logic [63:0] prod;

    always_ff @(posedge RF_CLK or posedge RF_RST) begin
        if (RF_RST) begin
            state_q <= IDLE;
            count_q <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? RUN : IDLE;
            RUN:     state_d = (count_q == 6'd31) ? FIN : RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rs_neg   = op[0] & rs[31];
        rt_neg   = op[0] & rt[31];
        rs_mag   = rs_neg ? -rs : rs;
        rt_mag   = rt_neg ? -rt : rt;
        sum      = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
        shl      = {rem_q[31:0], acc_q[31]};
        diff     = shl - {1'b0, b_q};
        prod     = neg_q ? -acc_q : acc_q;
        quo      = neg_q ? -acc_q[31:0] : acc_q[31:0];
        rmd      = rneg_q ? -rem_q[31:0] : rem_q[31:0];
        dividend = rneg_q ? -a_q : a_q;
        count_d  = count_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = rs_mag;
                    b_d     = rt_mag;
                    neg_d   = rs_neg ^ rt_neg;
                    rneg_d  = rs_neg;
                    count_d = '0;
                    dz_d    = 1'b0;
                    rem_d   = '0;
                    acc_d   = {32'd0, op[1] ? rs_mag : rt_mag};
                end else begin
                    hi_d = mthi ? rs : hi_q;
                    lo_d = mtlo ? rs : lo_q;
                end
            end
            RUN: begin
                count_d = count_q + 6'd1;
                rem_d   = op_q[1] ? (diff[32] ? shl : diff) : rem_q;
                acc_d   = op_q[1] ? {32'd0, acc_q[30:0], ~diff[32]} : {sum, acc_q[31:1]};
            end
            default: begin
                done_d = 1'b1;
                dz_d   = op_q[1] & (b_q == 32'd0);
                hi_d   = op_q[1] ? (dz_d ? dividend : rmd) : prod[63:32];
                lo_d   = op_q[1] ? (dz_d ? 32'hFFFF_FFFF : quo) : prod[31:0];
            end
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = dz_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: random and directed checks of muldiv_unit against an arithmetic reference.
module tb_muldiv_unit;
    logic        RF_CLK, RF_RST, start, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] rs, rt;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;
    int          checks = 0;
    int          failures = 0;

    muldiv_unit dut (
        .RF_CLK(RF_CLK), .RF_RST(RF_RST), .start(start), .op(op), .rs(rs), .rt(rt),
        .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .hi(hi), .lo(lo),
        .div_zero(div_zero)
    );

    initial begin
        RF_CLK = 1'b0;
        forever #5 RF_CLK = ~RF_CLK;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [64:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r, p;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (o[1]) begin
            if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
            if (o[0]) begin
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
            return {1'b0, a % b, a / b};
        end
        if (o[0]) begin
            p = sa * sb;
            return {1'b0, p[63:0]};
        end
        up = {32'd0, a} * {32'd0, b};
        return {1'b0, up};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit intrude);
        logic [64:0] r;
        int bad;
        r = ref_res(o, a, b);
        bad = 0;
        start = 1'b1; op = o; rs = a; rt = b;
        @(posedge RF_CLK); #1;
        start = 1'b0;
        chk("busy_e0", busy, 1);
        chk("done_e0", done, 0);
        chk("dz_clear", div_zero, 0);
        for (int c = 1; c <= 32; c++) begin
            rs = $urandom; rt = $urandom; op = 2'($urandom);
            mthi = 1'($urandom); mtlo = 1'($urandom);
            if (intrude && c == 10) begin
                start = 1'b1; op = 2'b10; rs = 32'h1234; rt = 32'd3; mthi = 1'b1; mtlo = 1'b0;
            end
            @(posedge RF_CLK); #1;
            start = 1'b0;
            if (busy !== 1'b1 || done !== 1'b0) bad++;
        end
        mthi = 1'b0; mtlo = 1'b0;
        chk("busy_run", bad, 0);
        @(posedge RF_CLK); #1;
        chk("done_fin", done, 1);
        chk("busy_fin", busy, 0);
        chk("hi", hi, r[63:32]);
        chk("lo", lo, r[31:0]);
        chk("div_zero", div_zero, r[64]);
    endtask

    task automatic mt(input bit h, input bit l, input logic [31:0] v);
        logic [31:0] eh, el;
        eh = h ? v : hi;
        el = l ? v : lo;
        mthi = h; mtlo = l; rs = v;
        @(posedge RF_CLK); #1;
        mthi = 1'b0; mtlo = 1'b0;
        chk("mt_hi", hi, eh);
        chk("mt_lo", lo, el);
        chk("mt_done", done, 0);
        chk("mt_busy", busy, 0);
    endtask

    initial begin
        int saw;
        RF_RST = 1'b1; start = 1'b0; op = '0; rs = '0; rt = '0; mthi = 1'b0; mtlo = 1'b0;
        #3;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dz", div_zero, 0);
        @(posedge RF_CLK); #1;
        RF_RST = 1'b0;
        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("multu_hi_const", hi, 32'hFFFF_FFFE);
        do_op(2'b01, 32'hFFFF_FFFD, 32'd7, 1'b0);
        chk("mult_lo_const", lo, 32'hFFFF_FFEB);
        do_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_lo_const", lo, 32'hFFFF_FFFD);
        do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("div_ovf_lo", lo, 32'h8000_0000);
        do_op(2'b10, 32'd100, 32'd0, 1'b0);
        chk("divz_hi", hi, 32'd100);
        do_op(2'b00, 32'd2, 32'd3, 1'b0);
        chk("multu6_lo", lo, 32'd6);
        do_op(2'b00, 32'd5, 32'd6, 1'b1);
        chk("intrude_lo", lo, 32'd30);
        mt(1'b0, 1'b1, 32'hABCD);
        mt(1'b1, 1'b1, $urandom);
        mt(1'b1, 1'b0, $urandom);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) mt(1'($urandom), 1'($urandom), $urandom);
            else do_op(2'($urandom), pick(), ($urandom_range(0, 7) == 0) ? 32'd0 : pick(), 1'b0);
        end
        do_op(2'b00, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
        start = 1'b1; op = 2'b11; rs = 32'hFFFF_0000; rt = 32'd7;
        @(posedge RF_CLK); #1;
        start = 1'b0;
        repeat (14) @(posedge RF_CLK);
        #1 RF_RST = 1'b1;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_hi", hi, 0);
        chk("rst_mid_lo", lo, 0);
        #1 RF_RST = 1'b0;
        saw = 0;
        repeat (40) begin
            @(posedge RF_CLK); #1;
            if (done === 1'b1 || busy === 1'b1) saw++;
        end
        chk("rst_no_done", saw, 0);
        chk("rst_hold_hi", hi, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
